flash_programmer: RTL and testbench

//  Write-side counterpart of the flash read controller: runs JS28F640 (16-bit mode) Word Program and Block Erase command sequences.

---
 rtl/flash_programmer_if.sv | 24 ++
 rtl/flash_programmer.sv | 179 +++++++++++++++++
 tb/tb_flash_programmer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/flash_programmer_if.sv
// Request/response bus between the system side and flash_programmer.
interface flash_programmer_if #(
  parameter int unsigned ADDR_WIDTH = 23
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_erase;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [15:0]           req_data;
  logic                  done;
  logic                  error;
  logic [7:0]            status;
  logic                  busy;

  modport master (
    output req_valid, req_erase, req_addr, req_data,
    input  req_ready, done, error, status, busy
  );

  modport slave (
    input  req_valid, req_erase, req_addr, req_data,
    output req_ready, done, error, status, busy
  );
endinterface

// File: rtl/flash_programmer.sv
// JS28F640 (16-bit mode) Word Program / Block Erase sequencer.
// Issues the two-write command, polls SR.7, clears status, returns the
// part to read-array mode and reports pass/fail with the last status byte.
module flash_programmer #(
  parameter int unsigned ADDR_WIDTH = 23,
  parameter int unsigned WE_CYCLES  = 4,
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned RD_CYCLES  = 6,
  parameter int unsigned TIMEOUT    = 2**24
) (
  input  logic                  clk,
  input  logic                  rst,
  flash_programmer_if.slave     bus,
  output logic [ADDR_WIDTH-1:0] flash_a,
  inout  wire  [15:0]           flash_d,
  output logic                  flash_rp_n,
  output logic                  flash_vpen,
  output logic                  flash_ce_n,
  output logic                  flash_oe_n,
  output logic                  flash_we_n,
  output logic                  flash_byte_n
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD1,
    S_CMD2,
    S_POLL,
    S_CHECK,
    S_CLR,
    S_ARRAY
  } state_t;

  localparam int unsigned WR_LEN   = WE_CYCLES + GAP_CYCLES;
  localparam int unsigned POLL_LEN = RD_CYCLES + 1;
  localparam int unsigned PH_MAX   = (WR_LEN > POLL_LEN) ? WR_LEN : POLL_LEN;
  localparam int unsigned CW       = $clog2(PH_MAX);
  localparam int unsigned PW       = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] WE_LAST   = CW'(WE_CYCLES - 1);
  localparam logic [CW-1:0] WR_LAST   = CW'(WR_LEN - 1);
  localparam logic [CW-1:0] RD_LAST   = CW'(RD_CYCLES - 1);
  localparam logic [CW-1:0] POLL_LAST = CW'(RD_CYCLES);
  localparam logic [PW-1:0] POLL_LIM  = PW'(TIMEOUT);

  // SR bits that flag a failed operation: 5 erase, 4 program, 3 VPP, 1 lock
  localparam logic [7:0] SR_ERR_MASK = 8'h3A;

  state_t                state_q, state_d;
  logic [CW-1:0]         ph_q, ph_d;
  logic [PW-1:0]         poll_q, poll_d;
  logic                  erase_q, erase_d;
  logic [ADDR_WIDTH-1:1] addr_q, addr_d;
  logic [15:0]           data_q, data_d;
  logic                  err_q, err_d;
  logic [7:0]            status_q, status_d;

  logic                  wr_state;
  logic                  rd_low;
  logic                  d_en;
  logic [15:0]           d_out;
  logic                  unused_bits;

  // a0 is meaningless in 16-bit mode and the upper data byte carries no status
  assign unused_bits = ^{bus.req_addr[0], flash_d[15:8]};

  // State and datapath registers; reset returns every pin-driving flop to idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ph_q     <= '0;
      poll_q   <= '0;
      erase_q  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      ph_q     <= ph_d;
      poll_q   <= poll_d;
      erase_q  <= erase_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      err_q    <= err_d;
      status_q <= status_d;
    end
  end

  // Next-state and datapath: phase counter paces each write/poll, CHECK decides
  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    poll_d   = poll_q;
    erase_d  = erase_q;
    addr_d   = addr_q;
    data_d   = data_q;
    err_d    = err_q;
    status_d = status_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          state_d = S_CMD1;
          ph_d    = '0;
          poll_d  = '0;
          err_d   = 1'b0;
          erase_d = bus.req_erase;
          addr_d  = bus.req_addr[ADDR_WIDTH-1:1];
          data_d  = bus.req_data;
        end
      end
      S_CMD1, S_CMD2, S_CLR, S_ARRAY: begin
        if (ph_q == WR_LAST) begin
          ph_d = '0;
          unique case (state_q)
            S_CMD1:  state_d = S_CMD2;
            S_CMD2:  state_d = S_POLL;
            S_CLR:   state_d = S_ARRAY;
            default: state_d = S_IDLE;
          endcase
        end else begin
          ph_d = ph_q + CW'(1);
        end
      end
      S_POLL: begin
        if (ph_q == RD_LAST) status_d = flash_d[7:0];
        if (ph_q == POLL_LAST) begin
          ph_d    = '0;
          state_d = S_CHECK;
        end else begin
          ph_d = ph_q + CW'(1);
        end
      end
      S_CHECK: begin
        if (status_q[7]) begin
          err_d   = |(status_q & SR_ERR_MASK);
          state_d = S_CLR;
        end else if (poll_q + PW'(1) == POLL_LIM) begin
          err_d   = 1'b1;
          state_d = S_CLR;
        end else begin
          poll_d  = poll_q + PW'(1);
          state_d = S_POLL;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pin and handshake outputs decoded from state and phase
  always_comb begin
    wr_state = (state_q == S_CMD1) || (state_q == S_CMD2) ||
               (state_q == S_CLR)  || (state_q == S_ARRAY);
    rd_low   = (state_q == S_POLL) && (ph_q <= RD_LAST);
    d_en     = wr_state;
    d_out    = 16'h00FF;
    unique case (state_q)
      S_CMD1:  d_out = erase_q ? 16'h0020 : 16'h0040;
      S_CMD2:  d_out = erase_q ? 16'h00D0 : data_q;
      S_CLR:   d_out = 16'h0050;
      default: d_out = 16'h00FF;
    endcase
    flash_we_n    = !(wr_state && (ph_q <= WE_LAST));
    flash_oe_n    = !rd_low;
    flash_ce_n    = !((wr_state && (ph_q <= WE_LAST)) || rd_low);
    flash_a       = (state_q == S_IDLE) ? '0 : {addr_q, 1'b0};
    flash_rp_n    = 1'b1;
    flash_byte_n  = 1'b1;
    flash_vpen    = (state_q != S_IDLE);
    bus.req_ready = (state_q == S_IDLE);
    bus.busy      = (state_q != S_IDLE);
    bus.done      = (state_q == S_ARRAY) && (ph_q == WR_LAST);
    bus.error     = err_q;
    bus.status    = status_q;
  end

  assign flash_d = d_en ? d_out : 16'hzzzz;

endmodule

// File: tb/tb_flash_programmer.sv
// Directed bench for flash_programmer with a behavioural flash status model.
module tb_flash_programmer;

  logic        clk = 1'b0;
  logic        rst;
  logic [22:0] flash_a;
  wire  [15:0] flash_d;
  logic        flash_rp_n, flash_vpen, flash_ce_n, flash_oe_n, flash_we_n, flash_byte_n;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // flash model state
  logic [7:0]  sr_m = 8'h00;
  int unsigned polls = 0;
  int unsigned m_nbusy = 0;
  logic [7:0]  m_ready = 8'h80;
  logic        prev_we = 1'b1;
  logic        prev_oe = 1'b1;
  logic [15:0] prev_d = '0;
  logic [22:0] prev_a = '0;
  logic [15:0] wlog[$];
  logic [22:0] alog[$];

  flash_programmer_if #(.ADDR_WIDTH(23)) bus ();

  flash_programmer #(
    .ADDR_WIDTH(23),
    .WE_CYCLES (4),
    .GAP_CYCLES(2),
    .RD_CYCLES (6),
    .TIMEOUT   (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .flash_a     (flash_a),
    .flash_d     (flash_d),
    .flash_rp_n  (flash_rp_n),
    .flash_vpen  (flash_vpen),
    .flash_ce_n  (flash_ce_n),
    .flash_oe_n  (flash_oe_n),
    .flash_we_n  (flash_we_n),
    .flash_byte_n(flash_byte_n)
  );

  always #5 clk = ~clk;

  // flash answers reads with the current status byte
  assign flash_d = (!flash_oe_n) ? {8'h00, sr_m} : 16'hzzzz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Model + pin-rule checker, evaluated mid-cycle
  always @(negedge clk) begin
    if (!flash_oe_n && prev_oe) begin
      sr_m  <= (polls < m_nbusy) ? 8'h00 : m_ready;
      polls <= polls + 1;
    end
    if (!flash_we_n && prev_we) begin
      wlog.push_back(flash_d);
      alog.push_back(flash_a);
    end
    check("we_oe_overlap_or_drive_during_read",
          {30'd0, !flash_we_n && !flash_oe_n, dut.d_en && !flash_oe_n}, 32'd0);
    if (!flash_we_n) check("vpen_during_write", {31'd0, flash_vpen}, 32'd1);
    if (!flash_we_n && !prev_we) begin
      check("d_stable_we_low", {16'd0, flash_d}, {16'd0, prev_d});
      check("a_stable_we_low", {9'd0, flash_a}, {9'd0, prev_a});
    end
    prev_we <= flash_we_n;
    prev_oe <= flash_oe_n;
    prev_d  <= flash_d;
    prev_a  <= flash_a;
  end

  task automatic run_op(input logic erase, input logic [22:0] addr, input logic [15:0] data,
                        input int unsigned nbusy, input logic [7:0] rdy_sr,
                        output int unsigned cyc, output logic err, output logic [7:0] st);
    @(posedge clk); #1;
    wlog.delete();
    alog.delete();
    polls   = 0;
    m_nbusy = nbusy;
    m_ready = rdy_sr;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_erase = erase;
    bus.req_addr  = addr;
    bus.req_data  = data;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_erase = ~erase;
    bus.req_addr  = 23'h7FFFFE;
    bus.req_data  = 16'h1234;
    cyc = 1;
    while (!bus.done && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
    end
    err = bus.error;
    st  = bus.status;
  endtask

  initial begin
    int unsigned cyc;
    logic        err;
    logic [7:0]  st;
    int unsigned guard;

    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_erase = 1'b0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    #12;
    check("rst_ready",  {31'd0, bus.req_ready}, 32'd1);
    check("rst_busy_done_err", {29'd0, bus.busy, bus.done, bus.error}, 32'd0);
    check("rst_status", {24'd0, bus.status}, 32'h00);
    check("rst_ce_oe_we", {29'd0, flash_ce_n, flash_oe_n, flash_we_n}, 32'd7);
    check("rst_addr", {9'd0, flash_a}, 32'd0);
    check("rst_vpen_rp_byte", {29'd0, flash_vpen, flash_rp_n, flash_byte_n}, 32'd3);
    check("rst_d_released", {31'd0, dut.d_en}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // program, ready on first poll
    run_op(1'b0, 23'h000100, 16'hBEEF, 0, 8'h80, cyc, err, st);
    check("prog_cycles", cyc, 32);
    check("prog_error", {31'd0, err}, 32'd0);
    check("prog_status", {24'd0, st}, 32'h80);
    check("prog_polls", polls, 1);
    check("prog_nwrites", wlog.size(), 4);
    check("prog_w0", {16'd0, wlog[0]}, 32'h0040);
    check("prog_w1", {16'd0, wlog[1]}, 32'hBEEF);
    check("prog_w2", {16'd0, wlog[2]}, 32'h0050);
    check("prog_w3", {16'd0, wlog[3]}, 32'h00FF);
    check("prog_a0", {9'd0, alog[0]}, 32'h000100);
    check("prog_a3", {9'd0, alog[3]}, 32'h000100);
    @(posedge clk); #1;
    check("prog_done_pulse", {31'd0, bus.done}, 32'd0);
    check("prog_ready_after", {30'd0, bus.req_ready, bus.busy}, 32'd2);

    // erase, busy for 5 polls
    run_op(1'b1, 23'h010000, 16'h0000, 5, 8'h80, cyc, err, st);
    check("erase_cycles", cyc, 72);
    check("erase_error", {31'd0, err}, 32'd0);
    check("erase_status", {24'd0, st}, 32'h80);
    check("erase_polls", polls, 6);
    check("erase_nwrites", wlog.size(), 4);
    check("erase_w0", {16'd0, wlog[0]}, 32'h0020);
    check("erase_w1", {16'd0, wlog[1]}, 32'h00D0);
    check("erase_w2", {16'd0, wlog[2]}, 32'h0050);
    check("erase_w3", {16'd0, wlog[3]}, 32'h00FF);
    check("erase_a1", {9'd0, alog[1]}, 32'h010000);

    // program failure reported by SR.4
    run_op(1'b0, 23'h000200, 16'h1357, 0, 8'h90, cyc, err, st);
    check("fail_cycles", cyc, 32);
    check("fail_error", {31'd0, err}, 32'd1);
    check("fail_status", {24'd0, st}, 32'h90);
    check("fail_w1", {16'd0, wlog[1]}, 32'h1357);
    check("fail_w2", {16'd0, wlog[2]}, 32'h0050);
    check("fail_w3", {16'd0, wlog[3]}, 32'h00FF);

    // never ready: TIMEOUT=8 polls then error
    run_op(1'b0, 23'h000300, 16'h0F0F, 1000, 8'h80, cyc, err, st);
    check("tmo_cycles", cyc, 88);
    check("tmo_polls", polls, 8);
    check("tmo_error", {31'd0, err}, 32'd1);
    check("tmo_status", {24'd0, st}, 32'h00);
    check("tmo_nwrites", wlog.size(), 4);
    check("tmo_w3", {16'd0, wlog[3]}, 32'h00FF);

    // reset while CMD2 holds we_n low
    @(posedge clk); #1;
    wlog.delete();
    alog.delete();
    polls   = 0;
    m_nbusy = 0;
    m_ready = 8'h80;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_erase = 1'b0;
    bus.req_addr  = 23'h000400;
    bus.req_data  = 16'hA5A5;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    guard = 0;
    while (wlog.size() < 2 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("rstmid_in_cmd2_we_low", {30'd0, wlog.size() == 2, flash_we_n}, 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check("rstmid_pins", {29'd0, flash_we_n, flash_ce_n, flash_oe_n}, 32'd7);
    check("rstmid_d_released", {31'd0, dut.d_en}, 32'd0);
    @(posedge clk); #1;
    check("rstmid_next_pins", {29'd0, flash_we_n, flash_ce_n, flash_oe_n}, 32'd7);
    check("rstmid_busy_ready_vpen", {29'd0, bus.busy, bus.req_ready, flash_vpen}, 32'd2);
    @(negedge clk);
    rst = 1'b0;

    // caller re-issues after reset
    run_op(1'b0, 23'h000400, 16'hA5A5, 0, 8'h80, cyc, err, st);
    check("reissue_cycles", cyc, 32);
    check("reissue_error", {31'd0, err}, 32'd0);
    check("reissue_w1", {16'd0, wlog[1]}, 32'hA5A5);

    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
